regfile_cc: RTL and testbench

REGFILE_CC -- requirements
Module: regfile_cc

---
 rtl/regfile_cc.sv | 92 +++++++++
 tb/tb_regfile_cc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_cc.sv
// Register file with zero-latency read ports, optional write-to-read forwarding,
// and the {N,Z,P} condition-code / branch-enable flops fed from the write-back bus.
module regfile_cc #(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned NREGS  = 8,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_REG,
  input  logic [AW-1:0]    DR,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  input  logic [WIDTH-1:0] D_in,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic [2:0]       IR_nzp,
  output logic [WIDTH-1:0] SR1_out,
  output logic [WIDTH-1:0] SR2_out,
  output logic             N,
  output logic             Z,
  output logic             P,
  output logic             BEN
);

  localparam bit         BYPASS_EN = (BYPASS != 0);
  localparam logic [2:0] CC_NEG    = 3'b100;
  localparam logic [2:0] CC_ZERO   = 3'b010;
  localparam logic [2:0] CC_POS    = 3'b001;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [2:0]       cc_q;
  logic [2:0]       cc_d;
  logic             ben_q;
  logic             ben_d;

  // Next-state: BEN samples the pre-edge codes, so a same-edge LD_CC is not seen.
  always_comb begin
    regs_d = regs_q;
    cc_d   = cc_q;
    ben_d  = ben_q;
    if (LD_REG) begin
      regs_d[DR] = D_in;
    end
    if (LD_CC) begin
      if (D_in == '0) begin
        cc_d = CC_ZERO;
      end else if (D_in[WIDTH-1]) begin
        cc_d = CC_NEG;
      end else begin
        cc_d = CC_POS;
      end
    end
    if (LD_BEN) begin
      ben_d = |(IR_nzp & cc_q);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      cc_q  <= CC_ZERO;
      ben_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cc_q   <= cc_d;
      ben_q  <= ben_d;
    end
  end

  // Read ports; forwarding is per port and stays live during reset.
  always_comb begin
    SR1_out = regs_q[SR1];
    SR2_out = regs_q[SR2];
    if (BYPASS_EN && LD_REG && (DR == SR1)) begin
      SR1_out = D_in;
    end
    if (BYPASS_EN && LD_REG && (DR == SR2)) begin
      SR2_out = D_in;
    end
  end

  assign N   = cc_q[2];
  assign Z   = cc_q[1];
  assign P   = cc_q[0];
  assign BEN = ben_q;

endmodule

// File: tb/tb_regfile_cc.sv
// Bench for regfile_cc: 16-bit/8-reg with and without forwarding plus a 32-bit/16-reg copy.
module tb_regfile_cc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ab_ld_reg = 0, ab_ld_cc = 0, ab_ld_ben = 0;
  logic [2:0]  ab_dr = '0, ab_sr1 = '0, ab_sr2 = '0, ab_nzp = '0;
  logic [15:0] ab_din = '0;
  logic [15:0] a_sr1, a_sr2, b_sr1, b_sr2;
  logic        a_n, a_z, a_p, a_ben, b_n, b_z, b_p, b_ben;

  logic        c_ld_reg = 0, c_ld_cc = 0, c_ld_ben = 0;
  logic [3:0]  c_dr = '0, c_sr1 = '0, c_sr2 = '0;
  logic [2:0]  c_nzp = '0;
  logic [31:0] c_din = '0;
  logic [31:0] c_sr1_o, c_sr2_o;
  logic        c_n, c_z, c_p, c_ben;

  regfile_cc #(.WIDTH(16), .NREGS(8), .BYPASS(1)) u_a (
    .Clk(clk), .Reset(rst_n), .LD_REG(ab_ld_reg), .DR(ab_dr), .SR1(ab_sr1), .SR2(ab_sr2),
    .D_in(ab_din), .LD_CC(ab_ld_cc), .LD_BEN(ab_ld_ben), .IR_nzp(ab_nzp),
    .SR1_out(a_sr1), .SR2_out(a_sr2), .N(a_n), .Z(a_z), .P(a_p), .BEN(a_ben));

  regfile_cc #(.WIDTH(16), .NREGS(8), .BYPASS(0)) u_b (
    .Clk(clk), .Reset(rst_n), .LD_REG(ab_ld_reg), .DR(ab_dr), .SR1(ab_sr1), .SR2(ab_sr2),
    .D_in(ab_din), .LD_CC(ab_ld_cc), .LD_BEN(ab_ld_ben), .IR_nzp(ab_nzp),
    .SR1_out(b_sr1), .SR2_out(b_sr2), .N(b_n), .Z(b_z), .P(b_p), .BEN(b_ben));

  regfile_cc #(.WIDTH(32), .NREGS(16), .BYPASS(1)) u_c (
    .Clk(clk), .Reset(rst_n), .LD_REG(c_ld_reg), .DR(c_dr), .SR1(c_sr1), .SR2(c_sr2),
    .D_in(c_din), .LD_CC(c_ld_cc), .LD_BEN(c_ld_ben), .IR_nzp(c_nzp),
    .SR1_out(c_sr1_o), .SR2_out(c_sr2_o), .N(c_n), .Z(c_z), .P(c_p), .BEN(c_ben));

  localparam int A1 = 0, A2 = 1, ACC = 2, ABEN = 3, B1 = 4, B2 = 5, BCC = 6, BBEN = 7;
  localparam int C1 = 8, C2 = 9, CCC = 10, CBEN = 11;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  typedef struct {
    bit          ld_reg;
    logic [2:0]  dr;
    logic [15:0] din;
    logic [2:0]  sr1, sr2;
    bit          ld_cc, ld_ben;
    logic [2:0]  nzp;
    logic [15:0] e_a1, e_a2, e_b1;
    logic [2:0]  e_cc;
    bit          e_ben;
  } vec_t;

  exp_t comb_q[$];
  exp_t post_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      A1:   return {16'h0, a_sr1};
      A2:   return {16'h0, a_sr2};
      ACC:  return {29'h0, a_n, a_z, a_p};
      ABEN: return {31'h0, a_ben};
      B1:   return {16'h0, b_sr1};
      B2:   return {16'h0, b_sr2};
      BCC:  return {29'h0, b_n, b_z, b_p};
      BBEN: return {31'h0, b_ben};
      C1:   return c_sr1_o;
      C2:   return c_sr2_o;
      CCC:  return {29'h0, c_n, c_z, c_p};
      default: return {31'h0, c_ben};
    endcase
  endfunction

  task automatic push(input bit post, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel = sel; e.exp = v; e.name = nm;
    if (post) post_q.push_back(e);
    else comb_q.push_back(e);
  endtask

  task automatic drain(input bit post);
    exp_t e;
    logic [31:0] got;
    while ((post ? post_q.size() : comb_q.size()) != 0) begin
      e = post ? post_q.pop_front() : comb_q.pop_front();
      got = obs(e.sel);
      n_cmp++;
      if (got !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (t=%0t)", e.name, got, e.exp, $time);
      end
    end
  endtask

  task automatic push_reset_state(input string tag, input logic [15:0] a2, input logic [31:0] c2);
    push(0, A1, 32'h0, {tag, " a_sr1"});   push(0, A2, {16'h0, a2}, {tag, " a_sr2"});
    push(0, B1, 32'h0, {tag, " b_sr1"});   push(0, B2, 32'h0, {tag, " b_sr2"});
    push(0, C1, 32'h0, {tag, " c_sr1"});   push(0, C2, c2, {tag, " c_sr2"});
    push(0, ACC, 32'h2, {tag, " a_cc"});   push(0, BCC, 32'h2, {tag, " b_cc"});
    push(0, CCC, 32'h2, {tag, " c_cc"});   push(0, ABEN, 32'h0, {tag, " a_ben"});
    push(0, BBEN, 32'h0, {tag, " b_ben"}); push(0, CBEN, 32'h0, {tag, " c_ben"});
  endtask

  function automatic vec_t mk(input bit lr, input logic [2:0] dr, input logic [15:0] din,
                              input logic [2:0] s1, input logic [2:0] s2, input bit lc, input bit lb,
                              input logic [2:0] nzp, input logic [15:0] ea1, input logic [15:0] ea2,
                              input logic [15:0] eb1, input logic [2:0] ecc, input bit eben);
    vec_t v;
    v.ld_reg = lr; v.dr = dr; v.din = din; v.sr1 = s1; v.sr2 = s2; v.ld_cc = lc; v.ld_ben = lb;
    v.nzp = nzp; v.e_a1 = ea1; v.e_a2 = ea2; v.e_b1 = eb1; v.e_cc = ecc; v.e_ben = eben;
    return v;
  endfunction

  task automatic apply_ab(input vec_t v, input int idx);
    @(negedge clk);
    ab_ld_reg = v.ld_reg; ab_dr = v.dr; ab_din = v.din; ab_sr1 = v.sr1; ab_sr2 = v.sr2;
    ab_ld_cc = v.ld_cc; ab_ld_ben = v.ld_ben; ab_nzp = v.nzp;
    push(0, A1, {16'h0, v.e_a1}, $sformatf("v%0d a_sr1", idx));
    push(0, A2, {16'h0, v.e_a2}, $sformatf("v%0d a_sr2", idx));
    push(0, B1, {16'h0, v.e_b1}, $sformatf("v%0d b_sr1", idx));
    push(1, ACC, {29'h0, v.e_cc}, $sformatf("v%0d a_cc", idx));
    push(1, BCC, {29'h0, v.e_cc}, $sformatf("v%0d b_cc", idx));
    push(1, ABEN, {31'h0, v.e_ben}, $sformatf("v%0d a_ben", idx));
    push(1, BBEN, {31'h0, v.e_ben}, $sformatf("v%0d b_ben", idx));
    #1 drain(0);
    @(posedge clk);
    #1 drain(1);
  endtask

  task automatic apply_c(input bit lr, input logic [3:0] dr, input logic [31:0] din,
                         input logic [3:0] s1, input logic [3:0] s2, input bit lc, input bit lb,
                         input logic [2:0] nzp, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [2:0] ecc, input bit eben, input string nm);
    @(negedge clk);
    c_ld_reg = lr; c_dr = dr; c_din = din; c_sr1 = s1; c_sr2 = s2;
    c_ld_cc = lc; c_ld_ben = lb; c_nzp = nzp;
    push(0, C1, e1, {nm, " c_sr1"});
    push(0, C2, e2, {nm, " c_sr2"});
    push(1, CCC, {29'h0, ecc}, {nm, " c_cc"});
    push(1, CBEN, {31'h0, eben}, {nm, " c_ben"});
    #1 drain(0);
    @(posedge clk);
    #1 drain(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[14];
    logic [15:0] model_ab[8];
    logic [31:0] model_c[16];

    vt[0]  = mk(1, 3, 16'h1234, 3, 0, 0, 0, 3'b000, 16'h1234, 16'h0000, 16'h0000, 3'b010, 0);
    vt[1]  = mk(0, 0, 16'h0000, 3, 3, 0, 0, 3'b000, 16'h1234, 16'h1234, 16'h1234, 3'b010, 0);
    vt[2]  = mk(0, 0, 16'h0000, 3, 0, 1, 0, 3'b000, 16'h1234, 16'h0000, 16'h1234, 3'b010, 0);
    vt[3]  = mk(0, 0, 16'h8001, 3, 0, 1, 0, 3'b000, 16'h1234, 16'h0000, 16'h1234, 3'b100, 0);
    vt[4]  = mk(0, 0, 16'h7FFF, 3, 0, 1, 0, 3'b000, 16'h1234, 16'h0000, 16'h1234, 3'b001, 0);
    vt[5]  = mk(0, 0, 16'h8001, 3, 0, 1, 0, 3'b000, 16'h1234, 16'h0000, 16'h1234, 3'b100, 0);
    vt[6]  = mk(0, 0, 16'h0005, 3, 0, 1, 1, 3'b100, 16'h1234, 16'h0000, 16'h1234, 3'b001, 1);
    vt[7]  = mk(0, 0, 16'h0000, 3, 0, 0, 1, 3'b100, 16'h1234, 16'h0000, 16'h1234, 3'b001, 0);
    vt[8]  = mk(0, 0, 16'h0000, 3, 0, 0, 1, 3'b111, 16'h1234, 16'h0000, 16'h1234, 3'b001, 1);
    vt[9]  = mk(0, 0, 16'h0000, 3, 0, 0, 1, 3'b000, 16'h1234, 16'h0000, 16'h1234, 3'b001, 0);
    vt[10] = mk(1, 7, 16'hFFFF, 7, 3, 1, 0, 3'b000, 16'hFFFF, 16'h1234, 16'h0000, 3'b100, 0);
    vt[11] = mk(0, 0, 16'h0000, 7, 7, 0, 0, 3'b000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'b100, 0);
    vt[12] = mk(1, 5, 16'h0042, 5, 7, 0, 1, 3'b001, 16'h0042, 16'hFFFF, 16'h0000, 3'b100, 0);
    vt[13] = mk(0, 0, 16'h0000, 5, 5, 0, 1, 3'b110, 16'h0042, 16'h0042, 16'h0042, 3'b100, 1);

    // Reset state
    repeat (2) @(negedge clk);
    push_reset_state("reset", 16'h0, 32'h0);
    #1 drain(0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) apply_ab(vt[i], i);

    // Fill every register, then read every pair on both ports
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ab_ld_reg = 1; ab_ld_cc = 0; ab_ld_ben = 0; ab_dr = 3'(i); ab_din = 16'hA500 + 16'(i);
      model_ab[i] = 16'hA500 + 16'(i);
    end
    @(negedge clk);
    ab_ld_reg = 0;
    for (int s1 = 0; s1 < 8; s1++) begin
      for (int s2 = 0; s2 < 8; s2++) begin
        @(negedge clk);
        ab_sr1 = 3'(s1); ab_sr2 = 3'(s2);
        push(0, A1, {16'h0, model_ab[s1]}, $sformatf("walk a_sr1 %0d", s1));
        push(0, A2, {16'h0, model_ab[s2]}, $sformatf("walk a_sr2 %0d", s2));
        push(0, B2, {16'h0, model_ab[s2]}, $sformatf("walk b_sr2 %0d", s2));
        #1 drain(0);
      end
    end

    // Wide configuration
    apply_c(1, 3, 32'h0000_1234, 3, 0, 0, 0, 3'b000, 32'h1234, 32'h0, 3'b010, 0, "c1");
    apply_c(0, 0, 32'h0000_0000, 3, 0, 1, 0, 3'b000, 32'h1234, 32'h0, 3'b010, 0, "c2");
    apply_c(0, 0, 32'h8000_0001, 3, 0, 1, 0, 3'b000, 32'h1234, 32'h0, 3'b100, 0, "c3");
    apply_c(0, 0, 32'h0000_8000, 3, 0, 1, 0, 3'b000, 32'h1234, 32'h0, 3'b001, 0, "c4");
    apply_c(0, 0, 32'h7FFF_FFFF, 3, 0, 1, 0, 3'b000, 32'h1234, 32'h0, 3'b001, 0, "c5");
    apply_c(0, 0, 32'hFFFF_0000, 3, 0, 1, 0, 3'b000, 32'h1234, 32'h0, 3'b100, 0, "c6");
    apply_c(0, 0, 32'h0000_0005, 3, 0, 1, 1, 3'b100, 32'h1234, 32'h0, 3'b001, 1, "c7");
    apply_c(0, 0, 32'h0000_0000, 3, 0, 0, 1, 3'b100, 32'h1234, 32'h0, 3'b001, 0, "c8");
    apply_c(1, 15, 32'hDEAD_BEEF, 15, 3, 1, 0, 3'b000, 32'hDEADBEEF, 32'h1234, 3'b100, 0, "c9");
    apply_c(0, 0, 32'h0000_0000, 15, 3, 0, 1, 3'b100, 32'hDEADBEEF, 32'h1234, 3'b100, 1, "c10");

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c_ld_reg = 1; c_ld_cc = 0; c_ld_ben = 0; c_dr = 4'(i); c_din = 32'hA5A5_0000 + 32'(i);
      model_c[i] = 32'hA5A5_0000 + 32'(i);
    end
    @(negedge clk);
    c_ld_reg = 0;
    for (int s1 = 0; s1 < 16; s1++) begin
      for (int s2 = 0; s2 < 16; s2++) begin
        @(negedge clk);
        c_sr1 = 4'(s1); c_sr2 = 4'(s2);
        push(0, C1, model_c[s1], $sformatf("walk c_sr1 %0d", s1));
        push(0, C2, model_c[s2], $sformatf("walk c_sr2 %0d", s2));
        #1 drain(0);
      end
    end

    // Reset asserted mid-cycle with every load enable high
    @(negedge clk);
    ab_ld_reg = 1; ab_dr = 2; ab_din = 16'h0BAD; ab_ld_cc = 1; ab_ld_ben = 1; ab_nzp = 3'b111;
    ab_sr1 = 3; ab_sr2 = 2;
    c_ld_reg = 1; c_dr = 4; c_din = 32'h8000_0000; c_ld_cc = 1; c_ld_ben = 1; c_nzp = 3'b111;
    c_sr1 = 15; c_sr2 = 4;
    #2 rst_n = 1'b0;
    push_reset_state("midrst", 16'h0BAD, 32'h8000_0000);
    #1 drain(0);
    @(posedge clk);
    #1 push_reset_state("rsthold", 16'h0BAD, 32'h8000_0000);
    drain(0);

    @(negedge clk);
    ab_ld_reg = 0; ab_ld_cc = 0; ab_ld_ben = 0; ab_sr1 = 2; ab_sr2 = 3;
    c_ld_reg = 0; c_ld_cc = 0; c_ld_ben = 0; c_sr1 = 4; c_sr2 = 15;
    rst_n = 1'b1;
    push_reset_state("release", 16'h0, 32'h0);
    #1 drain(0);

    // First loads after release
    @(negedge clk);
    ab_ld_reg = 1; ab_dr = 2; ab_din = 16'h0077; ab_ld_cc = 1;
    c_ld_reg = 1; c_dr = 4; c_din = 32'hFFFF_FFFE; c_ld_cc = 1;
    push(1, ACC, 32'h1, "post a_cc"); push(1, BCC, 32'h1, "post b_cc");
    push(1, CCC, 32'h4, "post c_cc");
    @(posedge clk);
    #1 drain(1);
    @(negedge clk);
    ab_ld_reg = 0; ab_ld_cc = 0; c_ld_reg = 0; c_ld_cc = 0;
    push(0, A1, 32'h0077, "post a_sr1"); push(0, B1, 32'h0077, "post b_sr1");
    push(0, C1, 32'hFFFF_FFFE, "post c_sr1"); push(0, C2, 32'h0, "post c_sr2");
    #1 drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
